// File: rtl/bit_serial_tx.sv
// bit_serial_tx: parallel-to-serial operand transmitter for the bit-serial datapath.
// It accepts a WIDTH-bit word over a valid/ready handshake and sends it LSB-first.
// After the data bits it sends EXT sign-extension bits.
// It also drives the shift/sign strobes used by the downstream serial accumulator.
module bit_serial_tx #(
  parameter int WIDTH  = 8,
  parameter int EXT    = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_stall,
  output logic             o_bit,
  output logic             o_sign,
  output logic             o_con_shift,
  output logic             o_con_sign,
  output logic             o_last,
  output logic             o_busy
);

  localparam int CNT_W = $clog2(WIDTH + EXT);
  // Count value of the final data bit and of the final bit of the whole frame.
  localparam logic [CNT_W-1:0] CNT_DATA_END = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_END      = CNT_W'(WIDTH + EXT - 1);

  typedef enum logic [1:0] {IDLE, DATA, SIGN} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   sreg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sign_q;

  logic busy;
  logic last;
  logic ready;
  logic accept;
  logic advance;

  // Handshake and frame-progress terms shared by the FSM and the output decode.
  always_comb begin
    busy    = (state_q != IDLE);
    advance = busy & ~i_stall;
    last    = advance & (cnt_q == CNT_END);
    ready   = i_rst_n & ((state_q == IDLE) | last);
    accept  = i_valid & ready;
  end

  // Frame FSM: shift/count on each non-stalled bit cycle, reload on accept.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      if (advance) begin
        sreg_q <= sreg_q >> 1;
        cnt_q  <= cnt_q + 1'b1;
        if (state_q == DATA && cnt_q == CNT_DATA_END) begin
          state_q <= (EXT > 0) ? SIGN : IDLE;
        end else if (state_q == SIGN && cnt_q == CNT_END) begin
          state_q <= IDLE;
        end
      end
      // A word accepted on the last bit of a frame overrides the frame end,
      // so back-to-back words stream without a bubble.
      if (accept) begin
        state_q <= DATA;
        sreg_q  <= i_data;
        cnt_q   <= '0;
        sign_q  <= SIGNED ? i_data[WIDTH-1] : 1'b0;
      end
    end
  end

  // Output decode; everything is held at 0 while reset is asserted.
  always_comb begin
    o_ready     = 1'b0;
    o_bit       = 1'b0;
    o_sign      = 1'b0;
    o_con_shift = 1'b0;
    o_con_sign  = 1'b0;
    o_last      = 1'b0;
    o_busy      = 1'b0;
    if (i_rst_n) begin
      o_ready     = ready;
      o_sign      = sign_q;
      o_con_shift = advance;
      o_con_sign  = advance & (state_q == SIGN);
      o_last      = last;
      o_busy      = busy;
      case (state_q)
        DATA:    o_bit = sreg_q[0];
        SIGN:    o_bit = sign_q;
        default: o_bit = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_tx.sv
// tb_bit_serial_tx: drives three transmitter variants (signed EXT=8, unsigned EXT=8,
// signed EXT=0) with shared stimulus.
// Every cycle, each variant is compared against a frame-position reference model.
module tb_bit_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n, valid, stall;
  logic [7:0] data;

  logic rdy [3];
  logic bt  [3];
  logic sg  [3];
  logic sh  [3];
  logic cs  [3];
  logic ls  [3];
  logic bz  [3];

  always #5 clk = ~clk;

  bit_serial_tx #(.WIDTH(8), .EXT(8), .SIGNED(1'b1)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .o_ready(rdy[0]),
    .i_stall(stall), .o_bit(bt[0]), .o_sign(sg[0]), .o_con_shift(sh[0]),
    .o_con_sign(cs[0]), .o_last(ls[0]), .o_busy(bz[0]));

  bit_serial_tx #(.WIDTH(8), .EXT(8), .SIGNED(1'b0)) dut_u (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .o_ready(rdy[1]),
    .i_stall(stall), .o_bit(bt[1]), .o_sign(sg[1]), .o_con_shift(sh[1]),
    .o_con_sign(cs[1]), .o_last(ls[1]), .o_busy(bz[1]));

  bit_serial_tx #(.WIDTH(8), .EXT(0), .SIGNED(1'b1)) dut_z (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .o_ready(rdy[2]),
    .i_stall(stall), .o_bit(bt[2]), .o_sign(sg[2]), .o_con_shift(sh[2]),
    .o_con_sign(cs[2]), .o_last(ls[2]), .o_busy(bz[2]));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: whether a frame is active, how many bits of it have been sent,
  // the word, and the extension bit.
  int         extv [3] = '{8, 8, 0};
  bit         sgnv [3] = '{1'b1, 1'b0, 1'b1};
  bit         m_act  [3];
  int         m_pos  [3];
  logic [7:0] m_word [3];
  bit         m_ext  [3];

  logic [31:0] cap    [3];
  int          ncap   [3];
  int          run    [3];
  int          maxrun [3];
  int          ncsign [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int j = 0; j < 3; j++) begin
      cap[j] = '0; ncap[j] = 0; run[j] = 0; maxrun[j] = 0; ncsign[j] = 0;
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare outputs, advance the model.
  task automatic cycle(input bit r, input bit v, input logic [7:0] d, input bit s);
    @(negedge clk);
    rst_n = r; valid = v; data = d; stall = s;
    #1;
    for (int j = 0; j < 3; j++) begin
      logic [6:0] exp_o;
      logic [6:0] obs_o;
      bit         last_e;
      bit         rdy_e;
      bit         bit_e;
      int         flen;
      flen   = 8 + extv[j];
      last_e = m_act[j] && !s && (m_pos[j] == flen - 1);
      rdy_e  = !m_act[j] || last_e;
      bit_e  = m_act[j] ? ((m_pos[j] < 8) ? m_word[j][m_pos[j]] : m_ext[j]) : 1'b0;
      if (r)
        exp_o = {rdy_e, bit_e, m_ext[j], m_act[j] && !s,
                 m_act[j] && !s && (m_pos[j] >= 8), last_e, m_act[j]};
      else
        exp_o = '0;
      obs_o = {rdy[j], bt[j], sg[j], sh[j], cs[j], ls[j], bz[j]};
      check($sformatf("outs_dut%0d{rdy,bit,sign,shift,csign,last,busy}", j),
            32'(obs_o), 32'(exp_o));
      if (sh[j]) begin
        if (ncap[j] < 32) cap[j][ncap[j]] = bt[j];
        ncap[j]++;
        run[j]++;
        if (run[j] > maxrun[j]) maxrun[j] = run[j];
      end else begin
        run[j] = 0;
      end
      if (cs[j]) ncsign[j]++;
      if (!r) begin
        m_act[j] = 1'b0; m_pos[j] = 0; m_ext[j] = 1'b0;
      end else begin
        if (m_act[j] && !s) begin
          m_pos[j]++;
          if (m_pos[j] == flen) m_act[j] = 1'b0;
        end
        if (v && rdy_e) begin
          m_act[j]  = 1'b1;
          m_pos[j]  = 0;
          m_word[j] = d;
          m_ext[j]  = sgnv[j] ? d[7] : 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; data = 8'h00; stall = 1'b0;
    for (int j = 0; j < 3; j++) begin
      m_act[j] = 1'b0; m_pos[j] = 0; m_word[j] = 8'h00; m_ext[j] = 1'b0;
    end
    clr();

    // Reset held for three cycles, then a single A5 frame.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    clr();
    cycle(1'b1, 1'b1, 8'hA5, 1'b0);
    idle(17);
    check("a5_signed_stream", 32'(cap[0][15:0]), 32'hFFA5);
    check("a5_signed_nbits", 32'(ncap[0]), 32'd16);
    check("a5_signed_csign_cycles", 32'(ncsign[0]), 32'd8);
    check("a5_unsigned_stream", 32'(cap[1][15:0]), 32'h00A5);
    check("a5_ext0_stream", 32'(cap[2][7:0]), 32'hA5);

    // Positive word: extension bits are zero.
    clr();
    cycle(1'b1, 1'b1, 8'h35, 1'b0);
    idle(17);
    check("h35_stream", 32'(cap[0][15:0]), 32'h0035);

    // Back-to-back words with valid held: second word is accepted on the first word's last bit.
    clr();
    cycle(1'b1, 1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 8'h80, 1'b0);
    idle(18);
    check("b2b_stream", cap[0], 32'hFF80_0001);
    check("b2b_no_gap_run", 32'(maxrun[0]), 32'd32);

    // Stall for three cycles after the fourth bit.
    clr();
    cycle(1'b1, 1'b1, 8'hA5, 1'b0);
    idle(4);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
    idle(13);
    check("stall_stream", 32'(cap[0][15:0]), 32'hFFA5);
    check("stall_nbits", 32'(ncap[0]), 32'd16);

    // Reset during the fifth bit, then a fresh word.
    cycle(1'b1, 1'b1, 8'hA5, 1'b0);
    idle(4);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check("post_reset_ready", 32'(rdy[0]), 32'd1);
    clr();
    cycle(1'b1, 1'b1, 8'h0F, 1'b0);
    idle(17);
    check("post_reset_stream", 32'(cap[0][15:0]), 32'h000F);

    // Valid raised mid-frame is held until accepted on the last bit.
    clr();
    cycle(1'b1, 1'b1, 8'hA5, 1'b0);
    idle(5);
    for (int i = 0; i < 11; i++) cycle(1'b1, 1'b1, 8'hFF, 1'b0);
    idle(18);
    check("midframe_valid_stream", cap[0], 32'hFFFF_FFA5);

    // EXT=0 variant: exactly eight shifts and no sign-extension strobe.
    clr();
    cycle(1'b1, 1'b1, 8'h81, 1'b0);
    idle(10);
    check("ext0_h81_stream", 32'(cap[2][7:0]), 32'h81);
    check("ext0_h81_nbits", 32'(ncap[2]), 32'd8);
    check("ext0_csign_count", 32'(ncsign[2]), 32'd0);

    // Randomized traffic with occasional reset, stalls and valid toggling.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 149) != 0), ($urandom_range(0, 1) == 1),
            8'($urandom), ($urandom_range(0, 9) < 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
